lfsr_crypt_engine: RTL and testbench

Parametrised LFSR stream-cipher engine: a single-instance, mode-selectable successor to the fixed Lab 4 encryptor. It reads its configuration (preamble length, taps, seed) from data memory and runs in one of two modes. In encrypt mode it writes a padded, encrypted preamble plus the message. In decrypt mode it reads ciphertext, strips the preamble and writes plaintext. It sits between the testbench-facing top level and `dat_mem`, driving the memory read/write ports directly at one byte per cycle.

---
 rtl/crypt_pkg.sv | 19 +
 rtl/lfsr_n.sv | 20 ++
 rtl/lfsr_crypt_engine.sv | 129 ++++++++++++
 tb/tb_lfsr_crypt_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared types and constants for the LFSR stream-cipher engine
package crypt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_PRE,
      LD_TAPS,
      LD_START,
      SEED,
      RUN,
      DONE
   } crypt_state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   localparam logic [7:0] DEFAULT_PAD = 8'h5f;

endpackage

// File: rtl/lfsr_n.sv
// rtl/lfsr_n.sv - Fibonacci LFSR with load-over-advance priority
module lfsr_n #(
   parameter int LW = 6
) (
   input  logic          clk,
   input  logic          en,
   input  logic          load,
   input  logic [LW-1:0] taps,
   input  logic [LW-1:0] seed,
   output logic [LW-1:0] state
);

   always_ff @(posedge clk) begin
      if (load)
         state <= seed;
      else if (en)
         state <= {state[LW-2:0], ^(state & taps)};
   end

endmodule

// File: rtl/lfsr_crypt_engine.sv
// rtl/lfsr_crypt_engine.sv - mode-selectable LFSR encrypt/decrypt engine driving dat_mem
module lfsr_crypt_engine
   import crypt_pkg::*;
#(
   parameter int            DW       = 8,
   parameter int            AW       = 8,
   parameter int            LW       = 6,
   parameter int            MSG_LEN  = 50,
   parameter int            MAX_PRE  = 15,
   parameter logic [DW-1:0] PAD      = DW'(DEFAULT_PAD),
   parameter int            CFG_BASE = 61,
   parameter int            PT_BASE  = 0,
   parameter int            CT_BASE  = 64,
   parameter int            DEC_BASE = 128
) (
   input  logic          clk,
   input  logic          init,
   input  logic          start,
   input  logic          mode,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] data_out,
   output logic          write_en,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] data_in,
   output logic          busy,
   output logic          done
);

   localparam int KW = $clog2(MAX_PRE + MSG_LEN + 1);

   crypt_state_t  state;
   logic          mode_q;
   logic [KW-1:0] pre_len;
   logic [KW-1:0] k;
   logic [LW-1:0] taps;
   logic [LW-1:0] seed;
   logic [LW-1:0] lfsr_state;
   logic [DW-1:0] ks;
   logic [DW-1:0] src;
   logic [DW-1:0] value;
   logic          msg_phase;
   logic          last;

   // init reloads the LFSR with zero so it resets without a dedicated port
   lfsr_n #(.LW(LW)) u_lfsr (
      .clk   (clk),
      .en    (state == RUN),
      .load  (init || (state == SEED)),
      .taps  (taps),
      .seed  (init ? '0 : seed),
      .state (lfsr_state)
   );

   assign ks        = DW'(lfsr_state);
   assign msg_phase = (k >= pre_len);
   assign last      = (k == pre_len + KW'(MSG_LEN - 1));
   assign src       = ((mode_q == MODE_ENC) && !msg_phase) ? PAD : data_out;
   assign value     = src ^ ks;
   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = (state == DONE);

   always_comb begin
      raddr = '0;
      case (state)
         LD_PRE:   raddr = AW'(CFG_BASE);
         LD_TAPS:  raddr = AW'(CFG_BASE + 1);
         LD_START: raddr = AW'(CFG_BASE + 2);
         RUN: begin
            if (mode_q == MODE_DEC)
               raddr = AW'(CT_BASE) + AW'(k);
            else if (msg_phase)
               raddr = AW'(PT_BASE) + AW'(k) - AW'(pre_len);
         end
         default: raddr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state    <= IDLE;
         mode_q   <= MODE_ENC;
         pre_len  <= '0;
         taps     <= '0;
         seed     <= '0;
         k        <= '0;
         write_en <= 1'b0;
         waddr    <= '0;
         data_in  <= '0;
      end else begin
         write_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state  <= LD_PRE;
                  mode_q <= mode;
               end
            end
            LD_PRE: begin
               pre_len <= (data_out > DW'(MAX_PRE)) ? KW'(MAX_PRE) : KW'(data_out);
               state   <= LD_TAPS;
            end
            LD_TAPS: begin
               taps  <= data_out[LW-1:0];
               state <= LD_START;
            end
            LD_START: begin
               seed  <= data_out[LW-1:0];
               state <= SEED;
            end
            SEED: begin
               k     <= '0;
               state <= RUN;
            end
            RUN: begin
               // decrypt drops the preamble but still consumes its keystream
               write_en <= (mode_q == MODE_ENC) || msg_phase;
               waddr    <= (mode_q == MODE_ENC) ? AW'(CT_BASE) + AW'(k)
                                                : AW'(DEC_BASE) + AW'(k) - AW'(pre_len);
               data_in  <= value;
               k        <= k + 1'b1;
               if (last)
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// tb/tb_lfsr_crypt_engine.sv - directed self-checking bench for lfsr_crypt_engine
module tb_lfsr_crypt_engine;

   localparam int CFG = 61;
   localparam int CT  = 64;
   localparam int DEC = 128;

   logic       clk = 1'b0;
   logic       init;
   logic       start;
   logic       mode;
   logic [7:0] raddr;
   logic [7:0] data_out;
   logic       write_en;
   logic [7:0] waddr;
   logic [7:0] data_in;
   logic       busy;
   logic       done;

   logic [7:0] mem [0:255];
   logic       tb_we;
   logic [7:0] tb_waddr;
   logic [7:0] tb_wdata;
   int         wr_total = 0;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] pt [0:49];
   logic [7:0] exp_ct [0:64];
   string      msg = "Mr_Watson_come_here_I_want_to_see_you_immediately!";

   always #5 clk = ~clk;

   lfsr_crypt_engine dut (
      .clk      (clk),
      .init     (init),
      .start    (start),
      .mode     (mode),
      .raddr    (raddr),
      .data_out (data_out),
      .write_en (write_en),
      .waddr    (waddr),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done)
   );

   assign data_out = mem[raddr];

   always @(posedge clk) begin
      if (tb_we)
         mem[tb_waddr] <= tb_wdata;
      else if (write_en) begin
         mem[waddr] <= data_in;
         wr_total   <= wr_total + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] fill_val(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   task automatic poke(input int a, input logic [7:0] d);
      tb_we    = 1'b1;
      tb_waddr = 8'(a);
      tb_wdata = d;
      @(posedge clk);
      #1;
      tb_we = 1'b0;
   endtask

   task automatic load_cfg(input logic [7:0] pre, input logic [7:0] tp, input logic [7:0] sd);
      poke(CFG, pre);
      poke(CFG + 1, tp);
      poke(CFG + 2, sd);
   endtask

   task automatic clear_ct();
      for (int i = 0; i < 65; i++) poke(CT + i, 8'h00);
   endtask

   task automatic build_model(input int pre, input logic [5:0] tp, input logic [5:0] sd);
      logic [5:0] s;
      s = sd;
      for (int i = 0; i < pre + 50; i++) begin
         exp_ct[i] = ((i < pre) ? 8'h5f : pt[i - pre]) ^ {2'b00, s};
         s = {s[4:0], ^(s & tp)};
      end
   endtask

   task automatic compare_ct(input string tag, input int n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_ct%0d", tag, i), mem[CT + i], exp_ct[i]);
   endtask

   // cycle 1 is the cycle right after the accepting edge; done must appear in cycle 5+n
   task automatic do_run(input logic m, input int n, input string tag, input bit disturb,
                         input int exp_wr);
      int cyc;
      int w0;
      w0    = wr_total;
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_low"}, done, 0);
      while (!done && cyc < 200) begin
         if (disturb && cyc == 20) begin
            start = 1'b1;
            mode  = ~m;
         end else if (disturb && cyc == 21)
            start = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_latency"}, cyc, 5 + n);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_done_hold"}, done, 1);
      check({tag, "_writes"}, wr_total - w0, exp_wr);
      mode = m;
   endtask

   initial begin
      int w0;
      init     = 1'b1;
      start    = 1'b0;
      mode     = 1'b0;
      tb_we    = 1'b0;
      tb_waddr = '0;
      tb_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      init = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_write_en", write_en, 0);
      check("rst_raddr", raddr, 0);
      check("rst_waddr", waddr, 0);
      check("rst_data_in", data_in, 0);

      for (int i = 0; i < 256; i++) poke(i, fill_val(i));
      for (int j = 0; j < 50; j++) begin
         pt[j] = msg[j];
         poke(j, pt[j]);
      end

      // encrypt with pre_len 7, taps 0x21, seed 0x01
      load_cfg(8'd7, 8'h21, 8'h01);
      build_model(7, 6'h21, 6'h01);
      do_run(1'b0, 57, "enc", 1'b0, 57);
      check("enc_hand_ct0", mem[CT + 0], 8'h5e);
      check("enc_hand_ct1", mem[CT + 1], 8'h5c);
      check("enc_hand_ct6", mem[CT + 6], 8'h61);
      check("enc_hand_ct7", mem[CT + 7], 8'h70);
      check("enc_hand_ct8", mem[CT + 8], 8'h48);
      compare_ct("enc", 57);
      check("enc_ct57_untouched", mem[CT + 57], fill_val(CT + 57));

      // decrypt the ciphertext just produced
      do_run(1'b1, 57, "dec", 1'b0, 50);
      for (int j = 0; j < 50; j++)
         check($sformatf("dec_pt%0d", j), mem[DEC + j], pt[j]);
      check("dec_ct0_kept", mem[CT + 0], 8'h5e);
      check("dec_ct57_untouched", mem[CT + 57], fill_val(CT + 57));
      check("dec_dec50_untouched", mem[DEC + 50], fill_val(DEC + 50));

      // oversize preamble clamps to 15
      load_cfg(8'h20, 8'h21, 8'h01);
      build_model(15, 6'h21, 6'h01);
      do_run(1'b0, 65, "clamp", 1'b0, 65);
      check("clamp_hand_ct14", mem[CT + 14], exp_ct[14]);
      compare_ct("clamp", 65);

      // no preamble, zero seed: identity
      load_cfg(8'd0, 8'h21, 8'h00);
      do_run(1'b0, 50, "zero", 1'b0, 50);
      for (int j = 0; j < 50; j++)
         check($sformatf("zero_ct%0d", j), mem[CT + j], pt[j]);

      // init lands on the edge ending RUN index 10
      load_cfg(8'd7, 8'h21, 8'h01);
      build_model(7, 6'h21, 6'h01);
      clear_ct();
      w0    = wr_total;
      mode  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      check("init_busy", busy, 0);
      check("init_done", done, 0);
      check("init_write_en", write_en, 0);
      check("init_raddr", raddr, 0);
      check("init_waddr", waddr, 0);
      check("init_data_in", data_in, 0);
      repeat (10) @(posedge clk);
      #1;
      check("init_writes", wr_total - w0, 10);
      check("init_idle_busy", busy, 0);
      check("init_ct9", mem[CT + 9], exp_ct[9]);
      check("init_ct10_clear", mem[CT + 10], 8'h00);
      do_run(1'b0, 57, "post_init", 1'b0, 57);
      compare_ct("post_init", 57);

      // start re-pulse and mode flip mid-run are ignored
      clear_ct();
      do_run(1'b0, 57, "ignore", 1'b1, 57);
      compare_ct("ignore", 57);

      // back-to-back start straight out of DONE
      check("b2b_pre_done", done, 1);
      do_run(1'b0, 57, "b2b", 1'b0, 57);
      compare_ct("b2b", 57);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
